// File: rtl/clk_gen_pkg.sv
// Shared types, constants and config clamping helpers for the clock-waveform generator.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned DIV_MIN = 2;

  // Shortest legal period: one high and one low clk cycle.
  function automatic int unsigned clamp_div(input int unsigned div);
    int unsigned r;
    r = (div < DIV_MIN) ? DIV_MIN : div;
    return r;
  endfunction

  // High phase must leave at least one low cycle in the period.
  function automatic int unsigned clamp_high(input int unsigned high, input int unsigned div_l);
    int unsigned r;
    if (high < 1) begin
      r = 1;
    end else if (high > div_l - 1) begin
      r = div_l - 1;
    end else begin
      r = high;
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_phase_ctr.sv
// Phase counter for one output period: wraps at div_l-1 and predicts the next
// clk_out level and edge strobes from the next phase value.
module clk_phase_ctr #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             adv_i,
  input  logic [DIV_W-1:0] div_l_i,
  input  logic [DIV_W-1:0] high_l_i,
  output logic             clk_out_next_c,
  output logic             rise_next_c,
  output logic             fall_next_c,
  output logic             wrap_c
);

  logic [DIV_W-1:0] ph_q, ph_d, ph_nxt;

  always_comb begin
    wrap_c         = (ph_q == div_l_i - DIV_W'(1));
    ph_nxt         = wrap_c ? '0 : ph_q + DIV_W'(1);
    clk_out_next_c = (ph_nxt < high_l_i);
    rise_next_c    = (ph_nxt == '0);
    fall_next_c    = (ph_nxt == high_l_i);
    ph_d           = ph_q;
    if (clear_i) begin
      ph_d = '0;
    end else if (adv_i) begin
      ph_d = ph_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= '0;
    end else begin
      ph_q <= ph_d;
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Programmable divided clock generator with duty control, cycle counting and
// optional bounded run length.
module clk_div_gen
  import clk_gen_pkg::*;
#(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] high_cnt,
  input  logic [CNT_W-1:0] num_cycles,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_l_q, div_l_d, high_l_q, high_l_d;
  logic [DIV_W-1:0] div_c, high_c;
  logic [CNT_W-1:0] num_l_q, num_l_d, cnt_q, cnt_d, cnt_inc;
  logic             clk_q, clk_d, rise_q, rise_d, fall_q, fall_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             ph_clear, ph_adv;
  logic             co_nxt, rise_nxt, fall_nxt, wrap;
  logic             limit_hit;

  clk_phase_ctr #(
    .DIV_W(DIV_W)
  ) u_phase (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (ph_clear),
    .adv_i         (ph_adv),
    .div_l_i       (div_l_q),
    .high_l_i      (high_l_q),
    .clk_out_next_c(co_nxt),
    .rise_next_c   (rise_nxt),
    .fall_next_c   (fall_nxt),
    .wrap_c        (wrap)
  );

  always_comb begin
    div_c     = DIV_W'(clamp_div(32'(div)));
    high_c    = DIV_W'(clamp_high(32'(high_cnt), 32'(div_c)));
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    limit_hit = (num_l_q != '0) && (cnt_inc == num_l_q);
  end

  // Next state and next output register values.
  always_comb begin
    state_d  = state_q;
    div_l_d  = div_l_q;
    high_l_d = high_l_q;
    num_l_d  = num_l_q;
    cnt_d    = cnt_q;
    clk_d    = clk_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    ph_clear = 1'b0;
    ph_adv   = 1'b0;

    case (state_q)
      IDLE: begin
        ph_clear = 1'b1;
        clk_d    = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        if (en) begin
          div_l_d  = div_c;
          high_l_d = high_c;
          num_l_d  = num_cycles;
          cnt_d    = '0;
          clk_d    = 1'b1;
          rise_d   = 1'b1;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end

      RUN, STOP: begin
        ph_adv = 1'b1;
        clk_d  = co_nxt;
        rise_d = rise_nxt;
        fall_d = fall_nxt;
        if (state_q == RUN && !en) begin
          state_d = STOP;
        end
        if (wrap) begin
          cnt_d = cnt_inc;
          // Reaching the cycle limit wins over a pending stop.
          if (limit_hit) begin
            state_d  = DONE;
            ph_clear = 1'b1;
            clk_d    = 1'b0;
            rise_d   = 1'b0;
            fall_d   = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else if (state_q == STOP) begin
            state_d  = IDLE;
            ph_clear = 1'b1;
            clk_d    = 1'b0;
            rise_d   = 1'b0;
            fall_d   = 1'b0;
            busy_d   = 1'b0;
          end
        end
      end

      DONE: begin
        ph_clear = 1'b1;
        clk_d    = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        if (!en) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_l_q  <= DIV_W'(DIV_MIN);
      high_l_q <= DIV_W'(1);
      num_l_q  <= '0;
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_l_q  <= div_l_d;
      high_l_q <= high_l_d;
      num_l_q  <= num_l_d;
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign clk_out    = clk_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign cycle_cnt  = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: stimulus queues per-edge expected outputs
// written as hand-derived waveform patterns; a monitor pops and compares after each edge.
module tb_clk_div_gen;

  typedef struct {
    bit          sel;
    logic        co;
    logic        rp;
    logic        fp;
    logic        by;
    logic        dn;
    logic [15:0] cnt;
    string       nm;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        en_s;
  logic [7:0]  div;
  logic [7:0]  high;
  logic [15:0] num;

  logic        clk_out, rise_pulse, fall_pulse, busy, done;
  logic [15:0] cycle_cnt;
  logic        clk_out_s, rise_s, fall_s, busy_s, done_s;
  logic [2:0]  cycle_cnt_s;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  clk_div_gen u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div       (div),
    .high_cnt  (high),
    .num_cycles(num),
    .clk_out   (clk_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .cycle_cnt (cycle_cnt),
    .busy      (busy),
    .done      (done)
  );

  // Narrow counter instance for saturation.
  clk_div_gen #(.DIV_W(8), .CNT_W(3)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_s),
    .div       (div),
    .high_cnt  (high),
    .num_cycles(num[2:0]),
    .clk_out   (clk_out_s),
    .rise_pulse(rise_s),
    .fall_pulse(fall_s),
    .cycle_cnt (cycle_cnt_s),
    .busy      (busy_s),
    .done      (done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic push(input bit sel, input logic co, input logic rp, input logic fp,
                      input logic by, input logic dn, input int cnt, input string nm);
    exp_t x;
    x.sel = sel; x.co = co; x.rp = rp; x.fp = fp; x.by = by; x.dn = dn;
    x.cnt = 16'(cnt); x.nm = nm;
    exp_q.push_back(x);
  endtask

  // One clk edge with en driven and its expected outcome queued.
  task automatic step(input logic ev, input bit sel, input logic co, input logic rp,
                      input logic fp, input logic by, input logic dn, input int cnt,
                      input string nm);
    if (sel) en_s = ev; else en = ev;
    push(sel, co, rp, fp, by, dn, cnt, nm);
    @(negedge clk);
  endtask

  // Runs nper periods of the hand-written clk_out pattern; en drops from edge drop_at on.
  task automatic run_pat(input string pat, input int nper, input int cnt0, input int cmax,
                         input int drop_at, input bit sel, input string nm);
    int len;
    len = pat.len();
    for (int i = 0; i < nper * len; i++) begin
      int   k;
      int   c;
      logic co, fp;
      k  = i % len;
      co = (pat[k] == "1");
      fp = (k > 0) && (pat[k] == "0") && (pat[k-1] == "1");
      c  = cnt0 + i / len;
      if (c > cmax) c = cmax;
      step((i < drop_at), sel, co, (k == 0), fp, 1'b1, 1'b0, c, $sformatf("%s[%0d]", nm, i));
    end
  endtask

  // Monitor: compares the selected instance against the next queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp({e.nm, "/clk_out"},    16'(e.sel ? clk_out_s : clk_out),       16'(e.co));
      cmp({e.nm, "/rise"},       16'(e.sel ? rise_s : rise_pulse),       16'(e.rp));
      cmp({e.nm, "/fall"},       16'(e.sel ? fall_s : fall_pulse),       16'(e.fp));
      cmp({e.nm, "/busy"},       16'(e.sel ? busy_s : busy),             16'(e.by));
      cmp({e.nm, "/done"},       16'(e.sel ? done_s : done),             16'(e.dn));
      cmp({e.nm, "/cycle_cnt"},  e.sel ? 16'(cycle_cnt_s) : cycle_cnt,   e.cnt);
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; en_s = 1'b0;
    div = 8'd4; high = 8'd2; num = 16'd0;
    repeat (2) @(negedge clk);
    cmp("reset/clk_out",   16'(clk_out), 16'd0);
    cmp("reset/busy",      16'(busy),    16'd0);
    cmp("reset/done",      16'(done),    16'd0);
    cmp("reset/rise",      16'(rise_pulse), 16'd0);
    cmp("reset/cycle_cnt", cycle_cnt,    16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bounded run: 1100 x3, then DONE held while en high.
    div = 8'd4; high = 8'd2; num = 16'd3;
    run_pat("1100", 3, 0, 65535, 1000, 1'b0, "basic");
    step(1, 0, 0, 0, 0, 0, 1, 3, "basic_done");
    step(1, 0, 0, 0, 0, 0, 1, 3, "done_hold0");
    step(1, 0, 0, 0, 0, 0, 1, 3, "done_hold1");
    step(0, 0, 0, 0, 0, 0, 0, 3, "done_clr");
    step(0, 0, 0, 0, 0, 0, 0, 3, "idle_hold");

    // Clamping: div=1/high=0 -> toggle; div=5/high=9 -> 11110.
    div = 8'd1; high = 8'd0; num = 16'd2;
    run_pat("10", 2, 0, 65535, 1000, 1'b0, "clamp_lo");
    step(1, 0, 0, 0, 0, 0, 1, 2, "clamp_lo_done");
    step(0, 0, 0, 0, 0, 0, 0, 2, "clamp_lo_idle");
    div = 8'd5; high = 8'd9; num = 16'd1;
    run_pat("11110", 1, 0, 65535, 1000, 1'b0, "clamp_hi");
    step(1, 0, 0, 0, 0, 0, 1, 1, "clamp_hi_done");
    step(0, 0, 0, 0, 0, 0, 0, 1, "clamp_hi_idle");

    // Graceful stop: en sampled low at ph=1, period 11100000 completes.
    div = 8'd8; high = 8'd3; num = 16'd0;
    run_pat("11100000", 1, 0, 65535, 2, 1'b0, "stop");
    step(0, 0, 0, 0, 0, 0, 0, 1, "stop_end");
    step(0, 0, 0, 0, 0, 0, 0, 1, "stop_idle0");
    step(0, 0, 0, 0, 0, 0, 0, 1, "stop_idle1");

    // Config isolation: div change mid-run ignored until restart.
    div = 8'd4; high = 8'd2; num = 16'd0;
    run_pat("1100", 1, 0, 65535, 1000, 1'b0, "cfg_a");
    div = 8'd6;
    run_pat("1100", 1, 1, 65535, 1, 1'b0, "cfg_b");
    step(0, 0, 0, 0, 0, 0, 0, 2, "cfg_stop");
    run_pat("110000", 1, 0, 65535, 1000, 1'b0, "cfg_new");
    step(1, 0, 1, 1, 0, 1, 0, 1, "cfg_wrap");
    step(1, 0, 1, 0, 0, 1, 0, 1, "pre_rst");

    // Async reset during the high phase.
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst/clk_out",   16'(clk_out), 16'd0);
    cmp("async_rst/busy",      16'(busy),    16'd0);
    cmp("async_rst/cycle_cnt", cycle_cnt,    16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 1, 1, 0, 1, 0, 0, "rst_restart");
    step(1, 0, 1, 0, 0, 1, 0, 0, "rst_ph1");
    en = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Saturation on the 3-bit counter instance.
    div = 8'd2; high = 8'd1; num = 16'd0;
    run_pat("10", 10, 0, 7, 1000, 1'b1, "sat");
    step(1, 1, 1, 1, 0, 1, 0, 7, "sat_run");
    step(1, 1, 0, 0, 1, 1, 0, 7, "sat_run_lo");
    en_s = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    repeat (2) @(negedge clk);
    cmp("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
